// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// instruction field bounds, the HALT opcode and the sampled control payload.
package fetch_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned JIDX_MSB = 25;
    localparam int unsigned JIDX_W   = 26;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TMO_W    = 4;

    localparam logic [OPC_W-1:0] OPC_HALT = 6'b111111;
    localparam logic [TMO_W-1:0] TMO_MAX  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    // Control-unit / ALU results sampled when an instruction is accepted
    typedef struct packed {
        logic jump;
        logic branch;
        logic zero;
    } issue_ctrl_t;

    // Primary opcode field of an instruction word
    function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or sequential.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    input  logic            jump,
    input  logic            branch,
    input  logic            zero,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] jmp_tgt;
    logic            unused_opc;

    // Sequential address; wraps modulo 2^32 naturally
    assign pc4 = pc + XLEN'(4);

    // Word-aligned, sign-extended branch displacement
    assign br_off = {{(XLEN-IMM_W-2){instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};

    // Jump stays inside the 256 MB region of pc+4
    assign jmp_tgt = {pc4[XLEN-1:XLEN-4], instr[JIDX_MSB:0], 2'b00};

    // Opcode bits play no part in target arithmetic
    assign unused_opc = ^instr[OPC_MSB:OPC_LSB];

    // Jump wins over a taken branch
    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = jmp_tgt;
        end else if (branch && zero) begin
            next_pc = pc4 + br_off;
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: requests one word per instruction, waits for
// memory, presents it to the control unit and steers the PC on acceptance.
// Optional feature macro FETCH_TIMEOUT_EN: bounds WAIT to 16 cycles, then
// re-issues the same address and pulses fetch_retry.
module instr_fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] instr,
    output logic [OPC_W-1:0] opcode,
    output logic            instr_valid,
    input  logic            issue_ready,
    input  logic            jump,
    input  logic            branch,
    input  logic            zero,
    output logic [XLEN-1:0] pc,
`ifdef FETCH_TIMEOUT_EN
    output logic            fetch_retry,
`endif
    output logic            halted
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            imem_req_q;
    logic            instr_valid_q;
    logic            halted_q;
    logic [XLEN-1:0] npc_c;
    issue_ctrl_t     ctrl_c;

`ifdef FETCH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             retry_q, retry_d;
`endif

    assign ctrl_c = '{jump: jump, branch: branch, zero: zero};

    next_pc_calc u_next_pc (
        .pc      (pc_q),
        .instr   (instr_q),
        .jump    (ctrl_c.jump),
        .branch  (ctrl_c.branch),
        .zero    (ctrl_c.zero),
        .next_pc (npc_c)
    );

    // Next-state, PC and instruction capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d = '0;
        retry_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    pc_d    = RESET_PC;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    instr_d = imem_data;
                    state_d = ST_ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_MAX) begin
                    state_d = ST_REQ;
                    retry_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    pc_d    = npc_c;
                    state_d = (opcode_of(instr_q) == OPC_HALT) ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered strobes derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= (state_d == ST_REQ);
            instr_valid_q <= (state_d == ST_ISSUE);
            halted_q      <= (state_d == ST_HALT);
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // WAIT-cycle counter and one-cycle retry strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            retry_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            retry_q   <= retry_d;
        end
    end

    assign fetch_retry = retry_q;
`endif

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = opcode_of(instr_q);
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq. Two instances share all inputs; the
// second starts from a high RESET_PC so jump region and PC arithmetic are
// observed in two address ranges at once.
module tb_instr_fetch_seq;

    localparam logic [31:0] HI_PC = 32'h1000_0010;

    logic        clk = 1'b0;
    logic        rst, start, imem_valid, issue_ready, jump, branch, zero;
    logic [31:0] imem_data;

    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, pc;
    logic [5:0]  opcode;

    logic        hi_unused_req, hi_unused_valid, hi_halted;
    logic [31:0] hi_unused_addr, hi_unused_instr, hi_pc;
    logic [5:0]  hi_unused_opc;

`ifdef FETCH_TIMEOUT_EN
    logic        fetch_retry, hi_unused_retry;
`endif

    instr_fetch_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .issue_ready(issue_ready), .jump(jump), .branch(branch), .zero(zero),
        .pc(pc),
`ifdef FETCH_TIMEOUT_EN
        .fetch_retry(fetch_retry),
`endif
        .halted(halted)
    );

    instr_fetch_seq #(.RESET_PC(HI_PC)) dut_hi (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(hi_unused_req), .imem_addr(hi_unused_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .instr(hi_unused_instr), .opcode(hi_unused_opc), .instr_valid(hi_unused_valid),
        .issue_ready(issue_ready), .jump(jump), .branch(branch), .zero(zero),
        .pc(hi_pc),
`ifdef FETCH_TIMEOUT_EN
        .fetch_retry(hi_unused_retry),
`endif
        .halted(hi_halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_hi;
        logic [31:0] instr;
    } issue_t;

    logic [31:0] req_q[$];
    issue_t      iss_q[$];

    int checks = 0;
    int errors = 0;
    int lat_start = 0;
    bit lat_armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected requests and issues as the DUT presents them
    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr %h expected no request (t=%0t)", imem_addr, $time);
            end else begin
                chk("imem_addr", imem_addr, req_q.pop_front());
            end
        end
        if (instr_valid === 1'b1) begin
            if (lat_armed) begin
                chk("fetch_latency", 32'(cyc), 32'(lat_start + 3));
                lat_armed = 1'b0;
            end
            if (iss_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got instr %h expected instr_valid=0 (t=%0t)", instr, $time);
            end else begin
                chk("instr", instr, iss_q[0].instr);
                chk("opcode", 32'(opcode), 32'(iss_q[0].instr[31:26]));
                if (issue_ready) begin
                    chk("pc", pc, iss_q[0].pc);
                    chk("pc_hi", hi_pc, iss_q[0].pc_hi);
                    void'(iss_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One fetch transaction: memory answers after lat WAIT cycles, downstream
    // stalls hold cycles, then accepts with the given control results
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat,
                         input logic j, input logic b, input logic z, input int hold,
                         input bit poke_start,
                         input logic [31:0] exp_pc, input logic [31:0] exp_pc_hi);
        int n = 0;
        req_q.push_back(addr);
        iss_q.push_back('{exp_pc, exp_pc_hi, data});
        while (imem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no imem_req expected request for %h", addr);
            return;
        end
        tick();
        for (int i = 1; i < lat; i++) begin
            start = poke_start;
            tick();
            start = 1'b0;
        end
        imem_valid = 1'b1;
        imem_data  = data;
        tick();
        imem_valid = 1'b0;
        imem_data  = '0;
        for (int i = 0; i < hold; i++) begin
            imem_valid = 1'b1;
            imem_data  = ~data;
            tick();
            imem_valid = 1'b0;
            imem_data  = '0;
        end
        jump        = j;
        branch      = b;
        zero        = z;
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_hi", hi_pc, HI_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_data = '0;
        issue_ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_reset_state();

        // Straight-line, stalled, branch, jump, then HALT
        lat_start = cyc;
        lat_armed = 1'b1;
        pulse_start();
        fetch(32'h0000_0000, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 32'h0000_0000, HI_PC);
        fetch(32'h0000_0004, 32'h2000_0005, 3, 0, 1, 0, 5, 0, 32'h0000_0004, 32'h1000_0014);
        fetch(32'h0000_0008, 32'h1000_FFFE, 1, 0, 1, 1, 0, 0, 32'h0000_0008, 32'h1000_0018);
        fetch(32'h0000_0004, 32'h0800_0040, 2, 1, 1, 1, 0, 0, 32'h0000_0004, 32'h1000_0014);
        fetch(32'h0000_0100, 32'hFC00_0000, 1, 0, 0, 0, 1, 0, 32'h0000_0100, 32'h1000_0100);
        chk("halted", 32'(halted), 32'h1);
        chk("halt_instr_valid", 32'(instr_valid), 32'h0);
        pulse_start();
        repeat (8) tick();
        chk("halted_sticky", 32'(halted), 32'h1);
        chk("halt_pc", pc, 32'h0000_0104);
        chk("halt_pc_hi", hi_pc, 32'h1000_0104);

        // Reset in WAIT, then a late memory strobe
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk_reset_state();
        req_q.push_back(32'h0000_0000);
        pulse_start();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b0;
        imem_data  = '0;
        repeat (4) tick();
        chk("late_instr", instr, 32'h0);
        chk("late_instr_valid", 32'(instr_valid), 32'h0);
        chk("late_pc", pc, 32'h0);
        chk("late_halted", 32'(halted), 32'h0);

        // Backward branch below zero, wrap back to zero, start ignored in WAIT
        pulse_start();
        fetch(32'h0000_0000, 32'h1000_FFFE, 1, 0, 1, 1, 0, 0, 32'h0000_0000, HI_PC);
        fetch(32'hFFFF_FFFC, 32'h0000_0000, 3, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h1000_000C);
        fetch(32'h0000_0000, 32'hFC00_0000, 1, 0, 0, 0, 0, 0, 32'h0000_0000, HI_PC);
        chk("halted_2", 32'(halted), 32'h1);
        chk("halted_hi", 32'(hi_halted), 32'h1);

`ifdef FETCH_TIMEOUT_EN
        // Withheld memory response forces a retry of the same address
        begin
            int  n;
            bit  seen;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
            req_q.push_back(32'h0000_0000);
            pulse_start();
            n    = 0;
            seen = 1'b0;
            while (n < 40 && !seen) begin
                tick();
                n++;
                if (fetch_retry === 1'b1) seen = 1'b1;
            end
            chk("fetch_retry_seen", 32'(seen), 32'h1);
            chk("retry_imem_req", 32'(imem_req), 32'h1);
            fetch(32'h0000_0000, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 32'h0000_0000, HI_PC);
            chk("retry_pulse_done", 32'(fetch_retry), 32'h0);
        end
`endif

        repeat (3) tick();
        chk("req_queue_drained", 32'(req_q.size()), 32'h0);
        chk("issue_queue_drained", 32'(iss_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have port start: input, 1 bit; pulse that leaves IDLE and begins fetching at RESET_PC.
REQ-003 SHALL have ports imem_req (output, 1) and imem_addr (output, 32); read request and word address to instruction memory.
REQ-004 SHALL have ports imem_valid (input, 1) and imem_data (input, 32); read-data strobe and instruction word.
REQ-005 SHALL have ports instr (output, 32), opcode (output, 6, =instr[31:26]) and instr_valid (output, 1); instruction issued to the control unit.
REQ-006 SHALL have port issue_ready: input, 1 bit; downstream accepts the instruction when instr_valid && issue_ready.
REQ-007 SHALL have ports jump, branch and zero: inputs, 1 bit each; control-unit and ALU results, sampled on the accept cycle.
REQ-008 SHALL have ports pc (output, 32), current instruction address, and halted (output, 1), HALT reached.
REQ-009 SHALL have parameter RESET_PC, default 32'h0000_0000; fetch start address.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, ISSUE, HALT.
REQ-011 IDLE->REQ on start; pc<=RESET_PC.
REQ-012 REQ: imem_req=1, imem_addr=pc for exactly one cycle; next WAIT.
REQ-013 WAIT: on imem_valid, capture imem_data into instr; next ISSUE. Otherwise remain in WAIT.
REQ-014 imem_valid outside WAIT SHALL be ignored.
REQ-015 ISSUE: instr_valid=1; instr/opcode held stable until accepted.
REQ-016 On accept: next_pc = {pc4[31:28], instr[25:0], 2'b00} if jump; else pc4 + (sign-extended instr[15:0] << 2) if branch&&zero; else pc4, where pc4 = pc+4.
REQ-017 On accept: next state is REQ, or HALT if opcode==6'b111111.
REQ-018 jump has priority over branch when both are 1.
REQ-019 pc arithmetic SHALL be modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0.
REQ-020 Fetch-to-issue latency: REQ at cycle n, imem_valid at cycle n+1 gives instr_valid at n+2.
REQ-021 Minimum throughput: one instruction per 3 cycles.
REQ-022 HALT: halted=1, no further requests; exit only via rst.
REQ-023 start SHALL be ignored outside IDLE.

Reset
REQ-024 On rst: state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, halted=0.
REQ-025 rst SHALL override all other inputs, including mid-WAIT; a late imem_valid after reset SHALL be discarded.

Configuration
REQ-026 With FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL count WAIT cycles; on reaching 15 with no imem_valid, the FSM returns to REQ and re-issues the same pc, and the output fetch_retry SHALL pulse for 1 cycle.
REQ-027 Without FETCH_TIMEOUT_EN: no counter and no fetch_retry port; WAIT is unbounded.

Structure
REQ-028 State encoding, the HALT opcode constant 6'b111111 and the instruction field bounds SHALL live in the shared package fetch_pkg.
REQ-029 Next-PC computation SHALL be a combinational sub-module, next_pc_calc (inputs pc, instr, jump, branch, zero; output next_pc).

Verification
REQ-030 start; memory returns 32'h0000_0000 after 1 cycle, issue_ready=1 -> instr_valid at cycle 3, pc advances 0->4.
REQ-031 pc=8, beq with instr[15:0]=16'hFFFE, branch=1, zero=1 -> next pc=4.
REQ-032 pc=32'h1000_0010, instr[25:0]=26'h40, jump=1, branch=1, zero=1 -> next pc=32'h1000_0100.
REQ-033 Hold issue_ready=0 for 5 cycles -> instr stable, no imem_req; accept -> REQ follows.
REQ-034 Assert rst during WAIT, then drive imem_valid -> IDLE, instr_valid stays 0.
REQ-035 Issue opcode 6'b111111 -> halted=1 and no further imem_req. With FETCH_TIMEOUT_EN: withhold imem_valid -> fetch_retry pulses and imem_req re-asserts with the same addr.
